// File: rtl/mem_stage.sv
// mem_stage: memory-stage pipeline register with load byte/halfword extraction and forwarding view.
// Optional MEM_SKID_EN adds a one-entry skid register so ready no longer depends on wb_to_mem_ready.
module mem_stage #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [2*DATA_WIDTH+ADDR_WIDTH+3:0] exe_to_mem_bus,
  input  logic                               exe_to_mem_valid,
  output logic                               mem_to_exe_ready,
  output logic [DATA_WIDTH+ADDR_WIDTH:0]     mem_to_wb_bus,
  output logic                               mem_to_wb_valid,
  input  logic                               wb_to_mem_ready,
  output logic                               mem_fwd_valid,
  output logic [ADDR_WIDTH-1:0]              mem_fwd_addr,
  output logic [DATA_WIDTH-1:0]              mem_fwd_data,
  output logic                               mem_misalign
);
  localparam int BW = DATA_WIDTH + ADDR_WIDTH + 1;
  logic                  regw;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] alu, ld, res;
  logic [2:0]            inst;
  logic [1:0]            off;
  logic [7:0]            b;
  logic [15:0]           h;
  logic                  mis, in_xfer;
  logic [BW-1:0]         in_b, out_b;
  assign {regw, addr, alu, inst, ld} = exe_to_mem_bus;
  assign off = alu[1:0];
  // Misaligned accesses fall back to the aligned lane: offset[0] dropped for halves, word ignores offset.
  always_comb begin
    b = ld[{off, 3'b000} +: 8];
    h = ld[{off[1], 4'b0000} +: 16];
    mis = ((inst == 3'd2 || inst == 3'd5) && off[0]) || (inst == 3'd3 && off != 2'd0);
    res = inst == 3'd1 ? {{(DATA_WIDTH-8){b[7]}}, b} :
          inst == 3'd2 ? {{(DATA_WIDTH-16){h[15]}}, h} :
          inst == 3'd3 ? ld :
          inst == 3'd4 ? {{(DATA_WIDTH-8){1'b0}}, b} :
          inst == 3'd5 ? {{(DATA_WIDTH-16){1'b0}}, h} : alu;
  end
  assign in_b = {regw, addr, res};
  assign mem_to_wb_bus = out_b;
  assign mem_fwd_valid = mem_to_wb_valid && out_b[BW-1] && out_b[BW-2:DATA_WIDTH] != '0;
  assign mem_fwd_addr  = out_b[BW-2:DATA_WIDTH];
  assign mem_fwd_data  = out_b[DATA_WIDTH-1:0];
`ifdef MEM_SKID_EN
  logic          skid_valid, skid_mis, load_out;
  logic [BW-1:0] skid_b;
  assign mem_to_exe_ready = ~skid_valid;
  assign in_xfer  = exe_to_mem_valid & ~skid_valid;
  assign load_out = ~mem_to_wb_valid | wb_to_mem_ready;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_b <= '0;
      mem_to_wb_valid <= 1'b0;
      mem_misalign <= 1'b0;
      skid_b <= '0;
      skid_mis <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      mem_misalign <= load_out & (skid_valid ? skid_mis : in_xfer & mis);
      if (load_out) begin
        mem_to_wb_valid <= skid_valid | in_xfer;
        out_b <= skid_valid ? skid_b : in_xfer ? in_b : out_b;
        skid_valid <= 1'b0;
      end else if (in_xfer) begin
        skid_b <= in_b;
        skid_mis <= mis;
        skid_valid <= 1'b1;
      end
    end
`else
  assign mem_to_exe_ready = ~mem_to_wb_valid | wb_to_mem_ready;
  assign in_xfer = exe_to_mem_valid & mem_to_exe_ready;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_b <= '0;
      mem_to_wb_valid <= 1'b0;
      mem_misalign <= 1'b0;
    end else begin
      mem_misalign <= in_xfer & mis;
      mem_to_wb_valid <= in_xfer | (mem_to_wb_valid & ~wb_to_mem_ready);
      out_b <= in_xfer ? in_b : out_b;
    end
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage; driver pushes expected bundles, monitor pops on output transfer.
module tb_mem_stage;
  typedef struct packed {
    logic        regw;
    logic [4:0]  addr;
    logic [31:0] res;
    logic        mis;
  } exp_t;
  typedef struct {
    logic        rw;
    logic [4:0]  a;
    logic [31:0] alu;
    logic [2:0]  inst;
    logic [31:0] ld;
    logic [31:0] res;
    logic        mis;
  } vec_t;
  logic        clk = 0, rst = 0;
  logic [72:0] exe_to_mem_bus = '0;
  logic        exe_to_mem_valid = 0, wb_to_mem_ready = 1;
  logic        mem_to_exe_ready, mem_to_wb_valid, mem_fwd_valid, mem_misalign;
  logic [37:0] mem_to_wb_bus;
  logic [4:0]  mem_fwd_addr;
  logic [31:0] mem_fwd_data;
  exp_t sb[$];
  int   errors = 0, checks = 0, cyc = 0, pops = 0, base;
  int   pop_cyc[64];
  bit   seen = 0;
  vec_t dir[8] = '{
    '{1, 5'd5, 32'h80000003, 3'd1, 32'h85123456, 32'hFFFFFF85, 0},
    '{1, 5'd6, 32'h00000002, 3'd5, 32'h9ABC1234, 32'h00009ABC, 0},
    '{1, 5'd6, 32'h00000002, 3'd2, 32'h9ABC1234, 32'hFFFF9ABC, 0},
    '{1, 5'd7, 32'h00000005, 3'd3, 32'h11223344, 32'h11223344, 1},
    '{1, 5'd8, 32'h00000003, 3'd2, 32'h7FFF0000, 32'h00007FFF, 1},
    '{1, 5'd9, 32'h00000001, 3'd4, 32'h0000F000, 32'h000000F0, 0},
    '{1, 5'd10, 32'hA5A5A5A5, 3'd6, 32'hFFFFFFFF, 32'hA5A5A5A5, 0},
    '{1, 5'd11, 32'h00000001, 3'd5, 32'h8001FFFF, 32'h0000FFFF, 1}};
  vec_t st[8] = '{
    '{1, 5'd1, 32'h00000010, 3'd0, 32'h00000000, 32'h00000010, 0},
    '{1, 5'd0, 32'h22222222, 3'd0, 32'h00000000, 32'h22222222, 0},
    '{1, 5'd2, 32'h00000002, 3'd4, 32'hAABBCCDD, 32'h000000BB, 0},
    '{1, 5'd3, 32'h00000002, 3'd1, 32'hAABBCCDD, 32'hFFFFFFBB, 0},
    '{0, 5'd4, 32'h00000000, 3'd5, 32'hAABBCCDD, 32'h0000CCDD, 0},
    '{1, 5'd5, 32'h00000000, 3'd2, 32'hAABBCCDD, 32'hFFFFCCDD, 0},
    '{1, 5'd0, 32'h12345678, 3'd7, 32'hFFFFFFFF, 32'h12345678, 0},
    '{1, 5'd7, 32'h00000001, 3'd3, 32'hCAFEF00D, 32'hCAFEF00D, 1}};

  mem_stage dut (
    .clk(clk), .rst(rst), .exe_to_mem_bus(exe_to_mem_bus), .exe_to_mem_valid(exe_to_mem_valid),
    .mem_to_exe_ready(mem_to_exe_ready), .mem_to_wb_bus(mem_to_wb_bus), .mem_to_wb_valid(mem_to_wb_valid),
    .wb_to_mem_ready(wb_to_mem_ready), .mem_fwd_valid(mem_fwd_valid), .mem_fwd_addr(mem_fwd_addr),
    .mem_fwd_data(mem_fwd_data), .mem_misalign(mem_misalign));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      seen = 0;
    end else if (mem_to_wb_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got bus %h expected no valid output", mem_to_wb_bus);
      end else begin
        chk("wb_bus", mem_to_wb_bus, {sb[0].regw, sb[0].addr, sb[0].res});
        chk("fwd_valid", mem_fwd_valid, sb[0].regw && sb[0].addr != 0);
        chk("fwd_addr", mem_fwd_addr, sb[0].addr);
        chk("fwd_data", mem_fwd_data, sb[0].res);
        chk("misalign", mem_misalign, seen ? 1'b0 : sb[0].mis);
        seen = 1;
        if (wb_to_mem_ready) begin
          void'(sb.pop_front());
          seen = 0;
          if (pops < 64) pop_cyc[pops] = cyc;
          pops++;
        end
      end
    end else chk("misalign_idle", mem_misalign, 1'b0);
  end

  task automatic send(input vec_t v);
    bit done = 0;
    exe_to_mem_bus = {v.rw, v.a, v.alu, v.inst, v.ld};
    exe_to_mem_valid = 1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (mem_to_exe_ready) begin
        sb.push_back('{v.rw, v.a, v.res, v.mis});
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    exe_to_mem_valid = 0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ready=%b expected 1", mem_to_exe_ready);
    end
  endtask

  task automatic drain;
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending=%0d expected 0", sb.size());
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, mem_to_wb_valid, 1'b0);
    chk({tag, "_bus"}, mem_to_wb_bus, 38'd0);
    chk({tag, "_fwd_valid"}, mem_fwd_valid, 1'b0);
    chk({tag, "_fwd_addr"}, mem_fwd_addr, 5'd0);
    chk({tag, "_fwd_data"}, mem_fwd_data, 32'd0);
    chk({tag, "_misalign"}, mem_misalign, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk_reset_outputs("reset");
    chk("reset_ready", mem_to_exe_ready, 1'b1);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1;
    foreach (dir[i]) send(dir[i]);
    drain();
    // Backpressure: hold A on the output for three cycles
    wb_to_mem_ready = 0;
    send('{1, 5'd3, 32'hDEADBEEF, 3'd0, 32'h00000000, 32'hDEADBEEF, 0});
`ifdef MEM_SKID_EN
    send('{1, 5'd4, 32'h0BADF00D, 3'd0, 32'h00000000, 32'h0BADF00D, 0});
    repeat (2) begin
      @(negedge clk);
      chk("stall_ready", mem_to_exe_ready, 1'b0);
      chk("stall_fwd_valid", mem_fwd_valid, 1'b1);
      chk("stall_fwd_addr", mem_fwd_addr, 5'd3);
    end
`else
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready", mem_to_exe_ready, 1'b0);
      chk("stall_fwd_valid", mem_fwd_valid, 1'b1);
      chk("stall_fwd_addr", mem_fwd_addr, 5'd3);
    end
`endif
    @(posedge clk);
    #1 wb_to_mem_ready = 1;
    drain();
    base = pops;
    foreach (st[i]) send(st[i]);
    drain();
    chk("stream_count", pops - base, 8);
    chk("stream_span", pop_cyc[base+7] - pop_cyc[base], 7);
    // Asynchronous reset while holding a stalled bundle
    wb_to_mem_ready = 0;
    send('{1, 5'd9, 32'h00000055, 3'd0, 32'h00000000, 32'h00000055, 0});
    @(negedge clk);
    #2 rst = 0;
    sb.delete();
    #1;
    chk_reset_outputs("async_rst");
    @(posedge clk);
    #1 wb_to_mem_ready = 1;
    @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("post_rst_ready", mem_to_exe_ready, 1'b1);
    @(posedge clk);
    #1;
    send('{1, 5'd12, 32'h00000000, 3'd1, 32'h00000080, 32'hFFFFFF80, 0});
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
